line_clear_ctrl: RTL

//  Sequences row clearing on the playfield after a piece locks. Priority-encodes the

---
 rtl/line_clear_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/line_clear_ctrl.sv
// Row-clear sequencer: after a piece locks, removes every full row lowest-first by
// shifting the rows above it down one position through a row-wide board RAM port.
module line_clear_ctrl #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int IDXW = 5,
  parameter int TOTW = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [ROWS-1:0] full_rows,
  output logic [IDXW-1:0] rd_addr,
  input  logic [COLS-1:0] rd_data,
  output logic            wr_en,
  output logic [IDXW-1:0] wr_addr,
  output logic [COLS-1:0] wr_data,
  output logic            busy,
  output logic            done,
  output logic [IDXW-1:0] lines_cleared,
  output logic [TOTW-1:0] total_lines
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIND,
    S_READ,
    S_WRITE,
    S_CLEAR_TOP,
    S_SETTLE,
    S_DONE
  } state_e;

  localparam logic [IDXW-1:0] TOP_ROW = IDXW'(ROWS - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] row_q,   row_d;
  logic [IDXW-1:0] cnt_q,   cnt_d;
  logic [IDXW-1:0] lines_q, lines_d;
  logic [TOTW-1:0] total_q, total_d;

  logic [IDXW-1:0] low_idx;
  logic [TOTW:0]   total_sum;
  logic [TOTW-1:0] total_sat;

  // Scanning top-down lets the last hit win, leaving the lowest full row.
  always_comb begin
    low_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (full_rows[i]) low_idx = IDXW'(i);
    end
  end

  assign total_sum = {1'b0, total_q} + (TOTW + 1)'(cnt_q);
  assign total_sat = total_sum[TOTW] ? '1 : total_sum[TOTW-1:0];

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    total_d = total_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = S_FIND;
        end
      end
      S_FIND: begin
        if (full_rows == '0) begin
          // Results are latched on entry to DONE so they are valid with the pulse.
          lines_d = cnt_q;
          total_d = total_sat;
          state_d = S_DONE;
        end else begin
          row_d   = low_idx;
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = (row_q == TOP_ROW) ? S_CLEAR_TOP : S_WRITE;
      end
      S_WRITE: begin
        row_d   = row_q + IDXW'(1);
        state_d = S_READ;
      end
      S_CLEAR_TOP: begin
        cnt_d   = cnt_q + IDXW'(1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_FIND;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      total_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge values,
      // so the order of these statements does not matter.
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      total_q <= total_d;
    end
  end

  // Control outputs are pure decodes of the state and row registers. The board RAM
  // read port is registered, so forwarding rd_data in WRITE is flop-to-flop.
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign wr_en   = (state_q == S_WRITE) || (state_q == S_CLEAR_TOP);
  assign wr_addr = (state_q == S_CLEAR_TOP) ? TOP_ROW :
                   (state_q == S_WRITE)     ? row_q   : '0;
  assign wr_data = (state_q == S_WRITE) ? rd_data : '0;
  assign rd_addr = (state_q == S_READ && row_q != TOP_ROW) ? row_q + IDXW'(1) : '0;

  assign lines_cleared = lines_q;
  assign total_lines   = total_q;

endmodule
